// File: rtl/shift_abus_seq.sv
// shift_abus_seq
//   Multi-cycle sequencer for the A-operand shift bus. One request carries a
//   pipeline-1 control byte plus an AI operand. The byte is decoded into a
//   shift class (ASR / PASS / CLEAR) or flagged illegal. ASR is performed as
//   an arithmetic right shift of one bit per cycle. The final word is offered
//   to the consumer through a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   cpipe_valid  request valid
//   cpipe_ready  request ready (high only while idle)
//   cpipe_op     control byte
//   ai_data      AI operand
//   shamt        shift amount, used in ASR mode only
//   shift_valid  result valid (registered)
//   shift_ready  consumer accepts the result
//   shift_abus   shifted A bus result (registered)
//   illegal      op was outside the shift class (registered, qualifies shift_valid)
//   busy         sequencer is not idle (registered)

module shift_abus_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpipe_valid,
    output logic             cpipe_ready,
    input  logic [7:0]       cpipe_op,
    input  logic [WIDTH-1:0] ai_data,
    input  logic [CNT_W-1:0] shamt,
    output logic             shift_valid,
    input  logic             shift_ready,
    output logic [WIDTH-1:0] shift_abus,
    output logic             illegal,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               opLegal;
    logic               opAsr;
    logic               opClear;
    logic [CNT_W-1:0]   loadCnt;

    // Control byte decode. Only consumed at the accept edge.
    always_comb begin
        opLegal = ~cpipe_op[0] & ~cpipe_op[2] & ~cpipe_op[3] & ~cpipe_op[4]
                  & cpipe_op[5] & cpipe_op[7];
        opAsr   = opLegal & ~cpipe_op[6];
        opClear = opLegal & cpipe_op[6] & ~cpipe_op[1];
        loadCnt = opAsr ? shamt : '0;
    end

    // Next-state and datapath update. A zero count skips SHIFT entirely, so
    // PASS, CLEAR and illegal ops reach OUT one cycle after acceptance.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        valid_d   = valid_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                if (cpipe_valid) begin
                    // Illegal ops and CLEAR both present a zero word.
                    data_d    = (!opLegal || opClear) ? '0 : ai_data;
                    cnt_d     = loadCnt;
                    illegal_d = ~opLegal;
                    busy_d    = 1'b1;
                    if (loadCnt != '0) begin
                        state_d = SHIFT;
                        valid_d = 1'b0;
                    end else begin
                        state_d = OUT;
                        valid_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                // Sign-filling shift; large amounts settle on all sign bits.
                data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = OUT;
                    valid_d = 1'b1;
                end
            end

            OUT: begin
                if (shift_ready) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    busy_d    = 1'b0;
                    illegal_d = 1'b0;
                end
            end

            default: begin
                state_d   = IDLE;
                valid_d   = 1'b0;
                busy_d    = 1'b0;
                illegal_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign cpipe_ready = (state_q == IDLE);
    assign shift_valid = valid_q;
    assign shift_abus  = data_q;
    assign illegal     = illegal_q;
    assign busy        = busy_q;

endmodule

// File: doc/shift_abus_seq.md
Name: shift_abus_seq

Overview:
Multi-cycle sequencer for the A-operand shift bus. Accepts one pipeline control byte (CPIPE1s encoding) plus an AI operand per transaction. Decodes the shift class, performs arithmetic-right shifts one bit per cycle, and presents the final shiftAbus word through a valid/ready output handshake. It sits between the pipeline-1 control decode and the shifter consumer, replacing the single-bit combinational select with a counted sequence.

Parameters:
WIDTH, 32, operand and shift bus width (>=2)
CNT_W, 5, shift-amount width; max shift 2^CNT_W-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
cpipe_valid  input  1  request valid
cpipe_ready  output  1  request accepted when valid&ready
cpipe_op  input  8  CPIPE1s control byte, bits [7:0]
ai_data  input  WIDTH  AIprocessed operand
shamt  input  CNT_W  shift amount (ASR mode only)
shift_valid  output  1  result valid
shift_ready  input  1  consumer accepts result
shift_abus  output  WIDTH  shifted A bus result
illegal  output  1  op not in shift class; qualifies shift_valid
busy  output  1  state != IDLE

Behaviour:
- Shift class: op[0]=0, op[2]=0, op[3]=0, op[4]=0, op[5]=1, op[7]=1. Any other op is illegal.
- Mode decode within the class:
  - op[6]=0 selects ASR.
  - op[6]=1 with op[1]=1 selects PASS.
  - op[6]=1 with op[1]=0 selects CLEAR.
- Decode and count load happen only at the accept edge. Inputs are ignored at all other times.
- FSM states are IDLE, SHIFT, OUT.
  - IDLE: cpipe_ready=1. On accept, latch data and mode. Set cnt = shamt for ASR; cnt = 0 for PASS, CLEAR and illegal.
    - CLEAR and illegal latch data = 0. illegal flag register = 1 for illegal only.
    - Next state is SHIFT if cnt != 0, else OUT.
  - SHIFT: each cycle, data <= {data[W-1], data[W-1:1]} (sign fill) and cnt <= cnt-1. The edge where cnt==1 moves to OUT.
  - OUT: shift_valid=1. shift_abus and illegal are held stable until shift_ready is sampled high, then the FSM returns to IDLE.
- cpipe_ready=0 in SHIFT and OUT. There is no overlap: a new request is accepted at the earliest in the cycle after the output handshake.
- Latency: accept in cycle c gives shift_valid high from cycle c+1+n, where n is the effective count.
  - PASS, CLEAR and illegal therefore take 1 cycle.
  - shift_ready held high gives a throughput of one transaction per n+2 cycles.
- shamt >= WIDTH is legal. The result becomes all copies of the sign bit, with no saturation logic beyond natural shifting.
- shift_valid, shift_abus, illegal and busy are registered outputs. cpipe_ready is decoded from state only.
- Reset values:
  - State IDLE; cpipe_ready=1 after reset release.
  - shift_valid=0, shift_abus=0, illegal=0, busy=0, cnt=0.
- Reset mid-operation (SHIFT or OUT) discards the transaction immediately (async). No output handshake occurs for it.
- shift_ready high while not in OUT is ignored.
- cpipe_valid dropped during SHIFT or OUT has no effect.

Test Plan:
1. Reset, then op=0xA0, ai=0x8000_0000, shamt=4 accepted in cycle c → shift_valid rises in c+5 with shift_abus=0xF800_0000, illegal=0; busy high c+1..c+5.
2. op=0xE2 (PASS), ai=0x1234_5678, shamt=31 → shift_valid in c+1, shift_abus=0x1234_5678. Then op=0xE0 (CLEAR) → shift_abus=0, illegal=0.
3. op=0xA1 (op[0]=1), ai=0xFFFF_FFFF → shift_valid in c+1, shift_abus=0, illegal=1.
4. ASR of ai=0x4000_0000, shamt=31 → 0x0000_0000. Same shamt with ai=0xC000_0000 → 0xFFFF_FFFF.
5. Backpressure: hold shift_ready=0 for 6 cycles in OUT → shift_abus stable, cpipe_ready=0, and a new cpipe_valid is not accepted. Raising shift_ready gives IDLE next cycle, and a second request is accepted in the following cycle.
6. Assert rst during SHIFT (shamt=10, 3 shifts done) → all outputs 0 immediately. After release, cpipe_ready=1 and shift_valid is never raised for the aborted transaction.
